// File: rtl/qam16_symbol_feeder_pkg.sv
// QAM16 symbol feeder: shared FSM encoding and Gray level table.
// Levels are stored as multiples of the unit amplitude AMP.
package qam16_symbol_feeder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SYMS_PER_SYM = 16;

  localparam int LVL_00 = -3;
  localparam int LVL_01 = -1;
  localparam int LVL_11 = 1;
  localparam int LVL_10 = 3;

endpackage

// File: rtl/qam16_level_map.sv
// QAM16 Gray pair to signed level conversion.
// Purely combinational; one instance per rail.
module qam16_level_map #(
  parameter int width_sym = 16,
  parameter int AMP       = 8192
) (
  input  logic [1:0]           pair,
  output logic [width_sym-1:0] level
);
  import qam16_symbol_feeder_pkg::*;

  localparam logic [width_sym-1:0] L00 =
    width_sym'(LVL_00 * AMP);
  localparam logic [width_sym-1:0] L01 =
    width_sym'(LVL_01 * AMP);
  localparam logic [width_sym-1:0] L11 =
    width_sym'(LVL_11 * AMP);
  localparam logic [width_sym-1:0] L10 =
    width_sym'(LVL_10 * AMP);

  always_comb begin
    level = '0;
    unique case (1'b1)
      (pair == 2'b00): level = L00;
      (pair == 2'b01): level = L01;
      (pair == 2'b11): level = L11;
      (pair == 2'b10): level = L10;
    endcase
  end

endmodule

// File: rtl/qam16_symbol_feeder.sv
// QAM16 symbol feeder: serial bits -> 16-sample I/Q symbols.
// One pending slot lets the next symbol load with no gap cycle.
module qam16_symbol_feeder #(
  parameter int width_sym = 16,
  parameter int width_sel = 4,
  parameter int AMP       = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [width_sym-1:0] data_i,
  output logic [width_sym-1:0] data_q,
  output logic [width_sel-1:0] sel,
  output logic                 start,
  output logic                 underrun
);
  import qam16_symbol_feeder_pkg::*;

  state_t state, state_n;

  // Three shifted bits; the 4th goes straight into pending.
  logic [2:0] collect;
  logic [1:0] cnt;
  logic [3:0] pending;
  logic       pending_full;
  logic       accept;
  logic       load;
  logic       last;

  logic [width_sym-1:0] lvl_i, lvl_q;
  logic [width_sym-1:0] data_i_n, data_q_n;
  logic [width_sel-1:0] sel_n;
  logic                 start_n, underrun_n;

  assign bit_ready = !pending_full;
  assign accept    = bit_valid && bit_ready;
  assign last      = (sel == '1);

  qam16_level_map #(
    .width_sym (width_sym),
    .AMP       (AMP)
  ) u_map_i (
    .pair  (pending[3:2]),
    .level (lvl_i)
  );

  qam16_level_map #(
    .width_sym (width_sym),
    .AMP       (AMP)
  ) u_map_q (
    .pair  (pending[1:0]),
    .level (lvl_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collect      <= '0;
      cnt          <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (accept) begin
      if (cnt == 2'd3) begin
        pending      <= {collect, bit_in};
        pending_full <= 1'b1;
        cnt          <= '0;
        collect      <= '0;
      end else begin
        collect <= {collect[1:0], bit_in};
        cnt     <= cnt + 2'd1;
      end
    end else if (load) begin
      pending_full <= 1'b0;
    end
  end

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    data_i_n   = data_i;
    data_q_n   = data_q;
    sel_n      = sel;
    start_n    = start;
    underrun_n = 1'b0;
    unique case (state)
      IDLE: begin
        start_n  = 1'b0;
        sel_n    = '0;
        data_i_n = '0;
        data_q_n = '0;
        if (pending_full) begin
          load     = 1'b1;
          state_n  = RUN;
          start_n  = 1'b1;
          data_i_n = lvl_i;
          data_q_n = lvl_q;
        end
      end
      RUN: begin
        start_n = 1'b1;
        sel_n   = sel + 1'b1;
        if (last) begin
          sel_n = '0;
          if (pending_full) begin
            load     = 1'b1;
            data_i_n = lvl_i;
            data_q_n = lvl_q;
          end else begin
            state_n    = IDLE;
            start_n    = 1'b0;
            data_i_n   = '0;
            data_q_n   = '0;
            underrun_n = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      data_i   <= '0;
      data_q   <= '0;
      sel      <= '0;
      start    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      data_i   <= data_i_n;
      data_q   <= data_q_n;
      sel      <= sel_n;
      start    <= start_n;
      underrun <= underrun_n;
    end
  end

endmodule
